// File: rtl/rr_arb_pkg.sv
// rtl/rr_arb_pkg.sv - shared types, sizes and round-robin pick function for the mux arbiter
package rr_arb_pkg;
   localparam int N_REQ = 16;
   localparam int SEL_W = 4;

   typedef enum logic {IDLE, GRANT} arb_state_t;

   typedef struct packed {
      logic             found;
      logic [SEL_W-1:0] idx;
   } pick_t;

   // Scan from the far end back toward ptr so the last hit is the closest one.
   function automatic pick_t rr_pick(input logic [N_REQ-1:0] req, input logic [SEL_W-1:0] ptr);
      pick_t            r;
      logic [SEL_W-1:0] k;
      r.found = 1'b0;
      r.idx   = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         k = ptr + SEL_W'(i);
         if (req[k]) begin
            r.found = 1'b1;
            r.idx   = k;
         end
      end
      return r;
   endfunction
endpackage

// File: rtl/mux16to1.sv
// rtl/mux16to1.sv - 16:1 single-bit select datapath
module mux16to1 (
   input  logic [15:0] in,
   input  logic [3:0]  sel,
   output logic        out
);
   assign out = in[sel];
endmodule

// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - round-robin arbiter with hold limit driving a 16:1 bit mux
module rr_mux_arbiter
   import rr_arb_pkg::*;
#(
   parameter int MAX_HOLD = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] data_in,
   output logic [N_REQ-1:0] gnt,
   output logic [SEL_W-1:0] sel,
   output logic             valid,
   output logic             data_out
);
   arb_state_t       state, state_nxt;
   logic [N_REQ-1:0] gnt_nxt;
   logic [SEL_W-1:0] sel_nxt, ptr, ptr_nxt;
   logic [7:0]       hold_cnt, hold_nxt;
   logic             valid_nxt, mux_out;
   pick_t            pick;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         gnt      <= '0;
         sel      <= '0;
         valid    <= 1'b0;
         ptr      <= '0;
         hold_cnt <= '0;
      end else begin
         state    <= state_nxt;
         gnt      <= gnt_nxt;
         sel      <= sel_nxt;
         valid    <= valid_nxt;
         ptr      <= ptr_nxt;
         hold_cnt <= hold_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      gnt_nxt   = gnt;
      sel_nxt   = sel;
      valid_nxt = valid;
      ptr_nxt   = ptr;
      hold_nxt  = hold_cnt;
      pick      = rr_pick(req, ptr);
      case (state)
         IDLE: begin
            gnt_nxt   = '0;
            valid_nxt = 1'b0;
            hold_nxt  = '0;
            if (pick.found) begin
               state_nxt = GRANT;
               gnt_nxt   = N_REQ'(1) << pick.idx;
               sel_nxt   = pick.idx;
               valid_nxt = 1'b1;
            end
         end
         GRANT: begin
            // Either release cause gives the same single pointer update.
            if (!req[sel] || hold_cnt == 8'(MAX_HOLD - 1)) begin
               state_nxt = IDLE;
               gnt_nxt   = '0;
               valid_nxt = 1'b0;
               ptr_nxt   = sel + SEL_W'(1);
               hold_nxt  = '0;
            end else begin
               hold_nxt  = hold_cnt + 8'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   mux16to1 u_mux (
      .in  (data_in),
      .sel (sel),
      .out (mux_out)
   );

   assign data_out = valid & mux_out;
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb/tb_rr_mux_arbiter.sv - randomized self-checking bench for rr_mux_arbiter
module tb_rr_mux_arbiter;
   localparam int MAX_HOLD = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] req = '0;
   logic [15:0] data_in = '0;
   logic [15:0] gnt;
   logic [3:0]  sel;
   logic        valid;
   logic        data_out;

   int checks = 0;
   int failures = 0;

   // Reference model: busy flag, owner index, cycles granted so far, next priority index.
   bit m_busy = 0;
   int m_sel = 0;
   int m_held = 0;
   int m_ptr = 0;
   logic [15:0] m_data = '0;

   rr_mux_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .data_in  (data_in),
      .gnt      (gnt),
      .sel      (sel),
      .valid    (valid),
      .data_out (data_out)
   );

   always #5 clk = ~clk;

   function automatic logic [21:0] expected_outs();
      logic [15:0] g;
      logic        d;
      g = m_busy ? (16'h0001 << m_sel) : 16'h0000;
      d = m_busy ? m_data[m_sel] : 1'b0;
      return {g, 4'(m_sel), logic'(m_busy), d};
   endfunction

   task automatic step(input logic [15:0] r, input logic [15:0] d, input bit rst);
      bit found;
      @(negedge clk);
      req = r;
      data_in = d;
      rst_n = ~rst;
      m_data = d;
      if (rst) begin
         m_busy = 0; m_sel = 0; m_held = 0; m_ptr = 0;
      end else if (!m_busy) begin
         found = 0;
         for (int k = 0; k < 16; k++) begin
            if (!found && r[(m_ptr + k) % 16]) begin
               found = 1;
               m_busy = 1;
               m_sel = (m_ptr + k) % 16;
               m_held = 1;
            end
         end
      end else if (!r[m_sel] || m_held == MAX_HOLD) begin
         m_busy = 0;
         m_ptr = (m_sel + 1) % 16;
      end else begin
         m_held++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [21:0] exp_v;
      step(16'hFFFF, $urandom, 1);
      step(16'h0000, $urandom, 1);
      exp_v = expected_outs();
      checks++;
      if ({gnt, sel, valid, data_out} !== 22'h0) begin
         failures++;
         $display("FAIL reset_state got=%h want=%h", {gnt, sel, valid, data_out}, 22'h0);
      end
      checks++;
      if ({gnt, sel, valid, data_out} !== exp_v) begin
         failures++;
         $display("FAIL reset_model got=%h want=%h", {gnt, sel, valid, data_out}, exp_v);
      end
   endtask

   task automatic test_single();
      step(16'h0000, 16'h0000, 1);
      step(16'h0001, 16'h0001, 0);
      checks++;
      if (gnt !== 16'h0001 || sel !== 4'd0 || valid !== 1'b1 || data_out !== 1'b1) begin
         failures++;
         $display("FAIL single_grant got gnt=%h sel=%0d valid=%b dout=%b want 0001/0/1/1", gnt, sel, valid, data_out);
      end
      step(16'h0000, 16'h0001, 0);
      checks++;
      if (valid !== 1'b0 || gnt !== 16'h0000 || sel !== 4'd0) begin
         failures++;
         $display("FAIL single_release got gnt=%h sel=%0d valid=%b want 0000/0/0", gnt, sel, valid);
      end
      // ptr advanced to 1, so requester 1 beats requester 0
      step(16'h0003, 16'h0002, 0);
      checks++;
      if (gnt !== 16'h0002 || data_out !== 1'b1) begin
         failures++;
         $display("FAIL single_ptr_adv got gnt=%h dout=%b want 0002/1", gnt, data_out);
      end
   endtask

   task automatic test_hold_wrap();
      logic [21:0] exp_v;
      int bad = 0;
      int order[$];
      logic prev_valid = 1'b0;
      step(16'h0000, 16'h0000, 1);
      for (int c = 0; c < 3 * (MAX_HOLD + 1); c++) begin
         step(16'h8001, $urandom, 0);
         exp_v = expected_outs();
         if ({gnt, sel, valid, data_out} !== exp_v) begin
            if (bad == 0) $display("FAIL hold_wrap_cycle%0d got=%h want=%h", c, {gnt, sel, valid, data_out}, exp_v);
            bad++;
         end
         if (valid && !prev_valid) order.push_back(int'(sel));
         prev_valid = valid;
      end
      checks++;
      if (bad != 0) failures++;
      checks++;
      if (order.size() != 3 || order[0] != 0 || order[1] != 15 || order[2] != 0) begin
         failures++;
         $display("FAIL hold_wrap_order got=%p want '{0,15,0}", order);
      end
   endtask

   task automatic test_drop();
      step(16'h0000, 16'h0000, 1);
      step(16'h0020, 16'h0020, 0);
      step(16'h0020, 16'h0020, 0);
      step(16'h0020, 16'h0020, 0);
      checks++;
      if (gnt !== 16'h0020 || sel !== 4'd5 || data_out !== 1'b1) begin
         failures++;
         $display("FAIL drop_held got gnt=%h sel=%0d dout=%b want 0020/5/1", gnt, sel, data_out);
      end
      step(16'h0008, 16'h0020, 0);
      checks++;
      if (valid !== 1'b0 || sel !== 4'd5) begin
         failures++;
         $display("FAIL drop_release got valid=%b sel=%0d want 0/5", valid, sel);
      end
      step(16'h0028, 16'h0000, 0);
      checks++;
      if (gnt !== 16'h0008 || sel !== 4'd3) begin
         failures++;
         $display("FAIL drop_next got gnt=%h sel=%0d want 0008/3", gnt, sel);
      end
   endtask

   task automatic test_all();
      logic [21:0] exp_v;
      int bad = 0;
      int order[$];
      logic prev_valid = 1'b0;
      step(16'h0000, 16'h0000, 1);
      for (int c = 0; c < 16 * (MAX_HOLD + 1) + 2; c++) begin
         step(16'hFFFF, $urandom, 0);
         exp_v = expected_outs();
         if ({gnt, sel, valid, data_out} !== exp_v) begin
            if (bad == 0) $display("FAIL all_cycle%0d got=%h want=%h", c, {gnt, sel, valid, data_out}, exp_v);
            bad++;
         end
         if (valid && !prev_valid) order.push_back(int'(sel));
         prev_valid = valid;
      end
      checks++;
      if (bad != 0) failures++;
      checks++;
      bad = (order.size() != 17) ? 1 : 0;
      for (int i = 0; i < order.size() && i < 17; i++) if (order[i] != i % 16) bad = 1;
      if (bad != 0) begin
         failures++;
         $display("FAIL all_order got=%p want 0..15,0", order);
      end
   endtask

   task automatic test_reset_mid();
      step(16'h0000, 16'h0000, 1);
      step(16'h0200, 16'h0200, 0);
      step(16'h0200, 16'h0200, 0);
      checks++;
      if (gnt !== 16'h0200 || sel !== 4'd9) begin
         failures++;
         $display("FAIL rstmid_grant got gnt=%h sel=%0d want 0200/9", gnt, sel);
      end
      step(16'h0200, 16'h0200, 1);
      checks++;
      if (gnt !== 16'h0000 || valid !== 1'b0 || sel !== 4'd0 || data_out !== 1'b0) begin
         failures++;
         $display("FAIL rstmid_clear got gnt=%h sel=%0d valid=%b dout=%b want 0/0/0/0", gnt, sel, valid, data_out);
      end
      step(16'h0204, 16'h0004, 0);
      checks++;
      if (gnt !== 16'h0004 || sel !== 4'd2 || data_out !== 1'b1) begin
         failures++;
         $display("FAIL rstmid_first got gnt=%h sel=%0d dout=%b want 0004/2/1", gnt, sel, data_out);
      end
   endtask

   task automatic test_idle();
      int bad = 0;
      step(16'h0000, 16'h0000, 1);
      for (int c = 0; c < 20; c++) begin
         step(16'h0000, $urandom, 0);
         if (gnt !== 16'h0000 || valid !== 1'b0 || data_out !== 1'b0) begin
            if (bad == 0) $display("FAIL idle_cycle%0d got gnt=%h valid=%b dout=%b want 0/0/0", c, gnt, valid, data_out);
            bad++;
         end
      end
      checks++;
      if (bad != 0) failures++;
   endtask

   task automatic test_random();
      logic [21:0] exp_v;
      logic [15:0] r;
      int bad = 0;
      step(16'h0000, 16'h0000, 1);
      r = 16'h0000;
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(3) == 0) r = 16'($urandom & $urandom & $urandom);
         step(r, $urandom, $urandom_range(60) == 0);
         exp_v = expected_outs();
         if ({gnt, sel, valid, data_out} !== exp_v) begin
            if (bad == 0) $display("FAIL random_cycle%0d got=%h want=%h", c, {gnt, sel, valid, data_out}, exp_v);
            bad++;
         end
      end
      checks++;
      if (bad != 0) failures++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_hold_wrap();
      test_drop();
      test_all();
      test_reset_mid();
      test_idle();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
